// File: rtl/arb_perfil_fun_if.sv
// rtl/arb_perfil_fun_if.sv - switch inputs and arbitration outputs of the profile/functionality arbiter
interface arb_perfil_fun_if #(
  parameter int N_IF   = 2,
  parameter int PERF_W = 3,
  parameter int FUN_W  = 3
);
  localparam int IDX_W = (N_IF > 2) ? $clog2(N_IF) : 1;

  logic [N_IF*PERF_W-1:0] perf_in;
  logic [N_IF*FUN_W-1:0]  fun_in;
  logic [FUN_W-1:0]       fun_act;
  logic [FUN_W*IDX_W-1:0] fun_own;
  logic [PERF_W-1:0]      disp_perf;
  logic                   auto_pilot;

  modport master (
    output perf_in, fun_in,
    input  fun_act, fun_own, disp_perf, auto_pilot
  );

  modport slave (
    input  perf_in, fun_in,
    output fun_act, fun_own, disp_perf, auto_pilot
  );
endinterface

// File: rtl/arb_perfil_fun.sv
// rtl/arb_perfil_fun.sv - level-checked, preemptive round-robin functionality arbiter with display and autopilot
module arb_perfil_fun #(
  parameter int N_IF    = 2,
  parameter int PERF_W  = 3,
  parameter int FUN_W   = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  arb_perfil_fun_if.slave   bus
);
  localparam int IDX_W = (N_IF > 2) ? $clog2(N_IF) : 1;
  localparam int LVL_W = $clog2(PERF_W + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_FREE, ST_HELD} own_st_e;

  logic [N_IF*PERF_W-1:0] perf_s1_q, perf_s2_q;
  logic [N_IF*FUN_W-1:0]  fun_s1_q, fun_s2_q;

  logic [N_IF-1:0]   prof_ok;
  logic [LVL_W-1:0]  lvl [N_IF];
  logic [FUN_W-1:0]  elig [N_IF];
  logic [PERF_W-1:0] ps_c;
  logic [FUN_W-1:0]  fs_c;

  own_st_e          st_q [FUN_W];
  own_st_e          st_d [FUN_W];
  logic [IDX_W-1:0] own_q [FUN_W];
  logic [IDX_W-1:0] own_d [FUN_W];
  logic [IDX_W-1:0] rr_q [FUN_W];
  logic [IDX_W-1:0] rr_d [FUN_W];

  logic             found;
  logic [IDX_W-1:0] win;
  logic [LVL_W-1:0] win_lvl;
  logic [IDX_W-1:0] scan_idx;

  logic [PERF_W-1:0] disp_q, disp_d;
  logic [1:0]        warm_q;
  logic [CNT_W-1:0]  nv_q, nv_d;
  logic              ap_q, ap_d;
  logic              any_valid;

  logic [FUN_W-1:0]       act_c;
  logic [FUN_W*IDX_W-1:0] own_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_s1_q <= '0;
      perf_s2_q <= '0;
      fun_s1_q  <= '0;
      fun_s2_q  <= '0;
    end else begin
      perf_s1_q <= bus.perf_in;
      perf_s2_q <= perf_s1_q;
      fun_s1_q  <= bus.fun_in;
      fun_s2_q  <= fun_s1_q;
    end
  end

  always_comb begin
    ps_c = '0;
    fs_c = '0;
    for (int i = 0; i < N_IF; i++) begin
      ps_c       = perf_s2_q[i*PERF_W +: PERF_W];
      fs_c       = fun_s2_q[i*FUN_W +: FUN_W];
      prof_ok[i] = $onehot(ps_c);
      lvl[i]     = '0;
      for (int b = 0; b < PERF_W; b++) begin
        if (ps_c[b] && prof_ok[i]) lvl[i] = LVL_W'(b + 1);
      end
      for (int j = 0; j < FUN_W; j++) begin
        elig[i][j] = prof_ok[i] && $onehot(fs_c) && fs_c[j] && (int'(lvl[i]) >= j + 1);
      end
    end
  end

  assign any_valid = |prof_ok;

  // Scanning upward from rr with a strict '>' keeps the first tied index as winner.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_lvl  = '0;
    scan_idx = '0;
    for (int j = 0; j < FUN_W; j++) begin
      st_d[j]  = st_q[j];
      own_d[j] = own_q[j];
      rr_d[j]  = rr_q[j];
      found    = 1'b0;
      win      = '0;
      win_lvl  = '0;
      for (int off = 0; off < N_IF; off++) begin
        scan_idx = IDX_W'((int'(rr_q[j]) + off) % N_IF);
        if (elig[scan_idx][j] && (!found || lvl[scan_idx] > win_lvl)) begin
          found   = 1'b1;
          win     = scan_idx;
          win_lvl = lvl[scan_idx];
        end
      end
      case (st_q[j])
        ST_FREE: begin
          if (found) begin
            st_d[j]  = ST_HELD;
            own_d[j] = win;
            rr_d[j]  = IDX_W'((int'(win) + 1) % N_IF);
          end
        end
        ST_HELD: begin
          if (!elig[own_q[j]][j]) begin
            st_d[j]  = ST_FREE;
            own_d[j] = '0;
          end else if (win_lvl > lvl[own_q[j]]) begin
            own_d[j] = win;
          end
        end
        default: begin
          st_d[j]  = ST_FREE;
          own_d[j] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < FUN_W; j++) begin
        st_q[j]  <= ST_FREE;
        own_q[j] <= '0;
        rr_q[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < FUN_W; j++) begin
        st_q[j]  <= st_d[j];
        own_q[j] <= own_d[j];
        rr_q[j]  <= rr_d[j];
      end
    end
  end

  // Display follows next-state ownership so it moves on the same edge as FUN_ACT/FUN_OWN.
  always_comb begin
    disp_d = '0;
    for (int j = 0; j < FUN_W; j++) begin
      if (st_d[j] == ST_HELD) disp_d = perf_s2_q[int'(own_d[j])*PERF_W +: PERF_W];
    end
  end

  // The no-profile count waits until the synchroniser holds real pin samples, not reset zeros.
  always_comb begin
    nv_d = nv_q;
    if (warm_q[1]) begin
      if (any_valid) nv_d = '0;
      else if (nv_q != CNT_W'(TIMEOUT)) nv_d = nv_q + CNT_W'(1);
    end
    ap_d = warm_q[1] && !any_valid && (nv_q == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_q <= '0;
      warm_q <= '0;
      nv_q   <= '0;
      ap_q   <= 1'b0;
    end else begin
      disp_q <= disp_d;
      warm_q <= {warm_q[0], 1'b1};
      nv_q   <= nv_d;
      ap_q   <= ap_d;
    end
  end

  always_comb begin
    act_c = '0;
    own_c = '0;
    for (int j = 0; j < FUN_W; j++) begin
      act_c[j]                  = (st_q[j] == ST_HELD);
      own_c[j*IDX_W +: IDX_W]   = own_q[j];
    end
  end

  assign bus.fun_act    = act_c;
  assign bus.fun_own    = own_c;
  assign bus.disp_perf  = disp_q;
  assign bus.auto_pilot = ap_q;

endmodule

// File: tb/tb_arb_perfil_fun.sv
// tb/tb_arb_perfil_fun.sv - scoreboard bench for arb_perfil_fun with directed vectors
module tb_arb_perfil_fun;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int         q_when [$];
  string      q_name [$];
  logic [9:0] q_exp  [$];

  arb_perfil_fun_if #(.N_IF(2), .PERF_W(3), .FUN_W(3)) bus ();

  arb_perfil_fun #(.N_IF(2), .PERF_W(3), .FUN_W(3), .TIMEOUT(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic at_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] p0, input logic [2:0] f0, input logic [2:0] p1, input logic [2:0] f1);
    bus.perf_in = {p1, p0};
    bus.fun_in  = {f1, f0};
  endtask

  task automatic expect_at(input int k, input string nm, input logic [2:0] act, input logic [2:0] own,
                           input logic [2:0] disp, input logic ap);
    q_when.push_back(cyc + k);
    q_name.push_back(nm);
    q_exp.push_back({act, own, disp, ap});
  endtask

  initial begin
    logic [9:0] exp_v, got_v;
    int         w;
    string      nm;
    forever begin
      @(posedge clk);
      #2;
      while (q_when.size() > 0 && q_when[0] <= cyc) begin
        w     = q_when.pop_front();
        nm    = q_name.pop_front();
        exp_v = q_exp.pop_front();
        got_v = {bus.fun_act, bus.fun_own, bus.disp_perf, bus.auto_pilot};
        n_cmp++;
        if (got_v !== exp_v || w != cyc) begin
          n_bad++;
          $display("FAIL %s cyc=%0d (due %0d): act=%b own=%b disp=%b ap=%b, required act=%b own=%b disp=%b ap=%b",
                   nm, cyc, w, got_v[9:7], got_v[6:4], got_v[3:1], got_v[0],
                   exp_v[9:7], exp_v[6:4], exp_v[3:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d checks pending", q_when.size());
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    expect_at(1, "reset_state", 3'b000, 3'b000, 3'b000, 1'b0);
    at_neg(2);
    rst_n = 1'b1;

    // autopilot from reset, release, glitch restart
    expect_at(10, "ap_before", 3'b000, 3'b000, 3'b000, 1'b0);
    expect_at(11, "ap_on",     3'b000, 3'b000, 3'b000, 1'b1);
    at_neg(11);
    drive(3'b000, 3'b000, 3'b010, 3'b000);
    expect_at(2, "ap_still", 3'b000, 3'b000, 3'b000, 1'b1);
    expect_at(3, "ap_off",   3'b000, 3'b000, 3'b000, 1'b0);
    at_neg(4);
    drive(3'b000, 3'b000, 3'b000, 3'b000);
    at_neg(7);
    drive(3'b000, 3'b000, 3'b010, 3'b000);
    at_neg(1);
    drive(3'b000, 3'b000, 3'b000, 3'b000);
    expect_at(3,  "ap_restart",    3'b000, 3'b000, 3'b000, 1'b0);
    expect_at(10, "ap_glitch_pre", 3'b000, 3'b000, 3'b000, 1'b0);
    expect_at(11, "ap_glitch_on",  3'b000, 3'b000, 3'b000, 1'b1);
    at_neg(12);

    // basic grant
    rst_n = 1'b0;
    at_neg(1);
    rst_n = 1'b1;
    drive(3'b100, 3'b001, 3'b000, 3'b000);
    expect_at(2, "grant_latency", 3'b000, 3'b000, 3'b000, 1'b0);
    expect_at(3, "basic_grant",   3'b001, 3'b000, 3'b100, 1'b0);
    at_neg(4);

    // access denial
    drive(3'b001, 3'b100, 3'b000, 3'b000);
    expect_at(3, "denial_release", 3'b000, 3'b000, 3'b000, 1'b0);
    expect_at(6, "denial",         3'b000, 3'b000, 3'b000, 1'b0);
    at_neg(6);

    // preemption
    drive(3'b001, 3'b001, 3'b000, 3'b000);
    expect_at(3, "low_grant", 3'b001, 3'b000, 3'b001, 1'b0);
    at_neg(4);
    drive(3'b001, 3'b001, 3'b010, 3'b001);
    expect_at(2, "preempt_hold", 3'b001, 3'b000, 3'b001, 1'b0);
    expect_at(3, "preempt",      3'b001, 3'b001, 3'b010, 1'b0);
    at_neg(4);

    // owner drop with a waiting lower-level requester
    drive(3'b001, 3'b001, 3'b010, 3'b000);
    expect_at(3, "release_idle",  3'b000, 3'b000, 3'b000, 1'b0);
    expect_at(4, "release_grant", 3'b001, 3'b000, 3'b001, 1'b0);
    at_neg(5);

    // tie round-robin
    rst_n = 1'b0;
    at_neg(1);
    rst_n = 1'b1;
    drive(3'b010, 3'b001, 3'b010, 3'b001);
    expect_at(3, "tie_first", 3'b001, 3'b000, 3'b010, 1'b0);
    expect_at(4, "tie_keep",  3'b001, 3'b000, 3'b010, 1'b0);
    at_neg(5);
    for (int k = 0; k < 3; k++) begin
      drive(3'b010, 3'b000, 3'b010, 3'b000);
      at_neg(1);
      drive(3'b010, 3'b001, 3'b010, 3'b001);
      expect_at(2, "tie_idle", 3'b000, 3'b000, 3'b000, 1'b0);
      expect_at(3, "tie_rr", 3'b001, (k % 2 == 0) ? 3'b001 : 3'b000, 3'b010, 1'b0);
      at_neg(5);
    end

    // async reset mid-grant
    drive(3'b100, 3'b010, 3'b010, 3'b001);
    expect_at(3, "two_held", 3'b011, 3'b001, 3'b100, 1'b0);
    at_neg(4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expect_at(0, "async_reset", 3'b000, 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    drive(3'b100, 3'b001, 3'b000, 3'b000);
    rst_n = 1'b1;
    expect_at(2, "post_reset_latency", 3'b000, 3'b000, 3'b000, 1'b0);
    expect_at(3, "post_reset_grant",   3'b001, 3'b000, 3'b100, 1'b0);
    at_neg(5);

    if (q_when.size() != 0) begin
      n_cmp += q_when.size();
      n_bad += q_when.size();
      $display("FAIL unchecked: %0d expected entries never compared, required 0", q_when.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
